// File: rtl/pingpong_fill_engine.sv
// -----------------------------------------------------------------------------
// pingpong_fill_engine
//
// Streams pixel words sequentially out of system memory and writes them
// alternately into two display buffers (Buffer0 / Buffer1). A full flag is
// published per buffer; a buffer is only refilled after the display controller
// releases it.
//
// Ports:
//   Clock        in   single clock, rising edge
//   ResetN       in   asynchronous active-low reset
//   Enable       in   permits new buffer fills to start
//   RESM         out  system-memory read enable
//   AddrSM       out  system-memory read address (free-running across buffers)
//   SMData       in   system-memory read data, valid the cycle after RESM
//   WData        out  buffer write data (shared), holds last written word
//   BufAddr      out  buffer write address, holds last written address
//   WE0 / WE1    out  per-buffer write enables (never both high)
//   Buf0Full     out  Buffer0 holds a complete, unconsumed block
//   Buf1Full     out  Buffer1 holds a complete, unconsumed block
//   Buf0Release  in   one-cycle pulse: Buffer0 consumed
//   Buf1Release  in   one-cycle pulse: Buffer1 consumed
//   FrameWrap    out  pulse in the cycle AddrSM wraps to 0
//   StallCount   out  cycles spent waiting for a buffer with Enable high
//
// Build option:
//   FILL_STALL_CNT_EN  when defined, StallCount is a saturating 16-bit
//                      counter; otherwise StallCount is tied to 0.
// -----------------------------------------------------------------------------
module pingpong_fill_engine #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 24,
    parameter int BUF_WORDS = 128,
    parameter int SM_WORDS  = 128
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              Enable,
    output logic              RESM,
    output logic [ADDR_W-1:0] AddrSM,
    input  logic [DATA_W-1:0] SMData,
    output logic [DATA_W-1:0] WData,
    output logic [ADDR_W-1:0] BufAddr,
    output logic              WE0,
    output logic              WE1,
    output logic              Buf0Full,
    output logic              Buf1Full,
    input  logic              Buf0Release,
    input  logic              Buf1Release,
    output logic              FrameWrap,
    output logic [15:0]       StallCount
);

    localparam logic [ADDR_W-1:0] BUF_LAST = ADDR_W'(BUF_WORDS - 1);
    localparam logic [ADDR_W-1:0] SM_LAST  = ADDR_W'(SM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, WAIT} state_t;

    state_t            state_reg, state_next;
    logic              target_reg, target_next;
    logic [ADDR_W-1:0] addr_sm_reg, addr_sm_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              resm_reg;
    logic              frame_wrap_reg, frame_wrap_next;
    logic [1:0]        full_reg, full_next, full_set, release_vec;

    // Write pipeline: one stage behind the read that produced the word.
    logic              wr_valid_reg;
    logic              wr_buf_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wdata_hold_reg;

    assign release_vec = {Buf1Release, Buf0Release};

    // Next-state and bookkeeping
    always_comb begin
        state_next      = state_reg;
        target_next     = target_reg;
        addr_sm_next    = addr_sm_reg;
        cnt_next        = cnt_reg;
        frame_wrap_next = 1'b0;
        full_set        = 2'b00;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (Enable) begin
                    state_next = full_reg[target_reg] ? WAIT : FILL;
                end
            end
            FILL: begin
                cnt_next = cnt_reg + 1'b1;
                if (addr_sm_reg == SM_LAST) begin
                    addr_sm_next    = '0;
                    frame_wrap_next = 1'b1;
                end else begin
                    addr_sm_next = addr_sm_reg + 1'b1;
                end
                if (cnt_reg == BUF_LAST) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // Last write lands this cycle; the block becomes full on
                // the closing edge and the other buffer becomes the target.
                full_set[target_reg] = 1'b1;
                target_next          = ~target_reg;
                cnt_next             = '0;
                if (!Enable) begin
                    state_next = IDLE;
                end else if (full_reg[~target_reg] && !release_vec[~target_reg]) begin
                    // A release arriving right now frees the buffer in time.
                    state_next = WAIT;
                end else begin
                    state_next = FILL;
                end
            end
            WAIT: begin
                cnt_next = '0;
                if (!full_reg[target_reg]) begin
                    state_next = Enable ? FILL : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_reg      <= IDLE;
            target_reg     <= 1'b0;
            addr_sm_reg    <= '0;
            cnt_reg        <= '0;
            resm_reg       <= 1'b0;
            frame_wrap_reg <= 1'b0;
            wr_valid_reg   <= 1'b0;
            wr_buf_reg     <= 1'b0;
            wr_addr_reg    <= '0;
            wdata_hold_reg <= '0;
        end else begin
            state_reg      <= state_next;
            target_reg     <= target_next;
            addr_sm_reg    <= addr_sm_next;
            cnt_reg        <= cnt_next;
            // RESM is registered but must track FILL exactly, so it is
            // derived from the state being entered.
            resm_reg       <= (state_next == FILL);
            frame_wrap_reg <= frame_wrap_next;
            wr_valid_reg   <= (state_reg == FILL);
            if (state_reg == FILL) begin
                wr_buf_reg  <= target_reg;
                wr_addr_reg <= cnt_reg;
            end
            if (wr_valid_reg) begin
                wdata_hold_reg <= SMData;
            end
        end
    end

    // Full flags: a release clears, a completed block sets. The buffer being
    // filled is never full, so set and clear never target the same flag.
    assign full_next = (full_reg & ~release_vec) | full_set;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_full
            always_ff @(posedge Clock or negedge ResetN) begin
                if (!ResetN) begin
                    full_reg[gi] <= 1'b0;
                end else begin
                    full_reg[gi] <= full_next[gi];
                end
            end
        end
    endgenerate

`ifdef FILL_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            stall_cnt_reg <= '0;
        end else if (state_reg == WAIT && Enable && stall_cnt_reg != 16'hFFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign StallCount = stall_cnt_reg;
`else
    assign StallCount = '0;
`endif

    assign RESM      = resm_reg;
    assign AddrSM    = addr_sm_reg;
    assign FrameWrap = frame_wrap_reg;
    assign Buf0Full  = full_reg[0];
    assign Buf1Full  = full_reg[1];
    assign WE0       = wr_valid_reg & ~wr_buf_reg;
    assign WE1       = wr_valid_reg & wr_buf_reg;
    assign BufAddr   = wr_addr_reg;
    // Memory data flows straight to the buffers; between writes the bus
    // keeps showing the last word written.
    assign WData     = wr_valid_reg ? SMData : wdata_hold_reg;

endmodule

// File: tb/tb_pingpong_fill_engine.sv
// -----------------------------------------------------------------------------
// Directed testbench for pingpong_fill_engine with BUF_WORDS=4, SM_WORDS=6 and
// system-memory word k = 24'h0A0000 + k. One line is printed per buffer write.
// -----------------------------------------------------------------------------
module tb_pingpong_fill_engine;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 24;

`ifdef FILL_STALL_CNT_EN
    localparam int STALL_EXP = 10;
`else
    localparam int STALL_EXP = 0;
`endif

    logic              clock;
    logic              reset_n;
    logic              enable;
    logic              resm;
    logic [ADDR_W-1:0] addr_sm;
    logic [DATA_W-1:0] sm_data;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] buf_addr;
    logic              we0, we1;
    logic              buf0_full, buf1_full;
    logic              rel0, rel1;
    logic              frame_wrap;
    logic [15:0]       stall_count;

    int passed = 0;
    int total  = 0;

    logic [DATA_W-1:0] buf0_mem [0:127];
    logic [DATA_W-1:0] buf1_mem [0:127];
    int wr0_cnt = 0;
    int wr1_cnt = 0;
    int both_err = 0;

    pingpong_fill_engine #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BUF_WORDS(4),
        .SM_WORDS (6)
    ) dut (
        .Clock      (clock),
        .ResetN     (reset_n),
        .Enable     (enable),
        .RESM       (resm),
        .AddrSM     (addr_sm),
        .SMData     (sm_data),
        .WData      (wdata),
        .BufAddr    (buf_addr),
        .WE0        (we0),
        .WE1        (we1),
        .Buf0Full   (buf0_full),
        .Buf1Full   (buf1_full),
        .Buf0Release(rel0),
        .Buf1Release(rel1),
        .FrameWrap  (frame_wrap),
        .StallCount (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // System memory: registered read, word k = 0A0000 + k
    initial sm_data = '0;
    always @(posedge clock) begin
        if (resm) sm_data <= 24'h0A0000 + {17'd0, addr_sm};
    end

    // Buffer write monitor
    always @(negedge clock) begin
        if (we0 && we1) both_err++;
        if (we0) begin
            buf0_mem[buf_addr] = wdata;
            wr0_cnt++;
            $display("write buf0 addr %0d data %06h", buf_addr, wdata);
        end
        if (we1) begin
            buf1_mem[buf_addr] = wdata;
            wr1_cnt++;
            $display("write buf1 addr %0d data %06h", buf_addr, wdata);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        rel0    = 1'b0;
        rel1    = 1'b0;
        tick(2);

        // Reset state
        check("rst_ctrl", {29'd0, resm, we0, we1}, 32'd0);
        check("rst_full", {30'd0, buf0_full, buf1_full}, 32'd0);
        check("rst_wrap", {31'd0, frame_wrap}, 32'd0);
        check("rst_stall", {16'd0, stall_count}, 32'd0);
        check("rst_addrsm", {25'd0, addr_sm}, 32'd0);
        check("rst_bufaddr", {25'd0, buf_addr}, 32'd0);
        check("rst_wdata", {8'd0, wdata}, 32'd0);

        // Fill Buffer0 then Buffer1 with no releases
        reset_n = 1'b1;
        enable  = 1'b1;
        tick(1);
        check("fill0_resm", {31'd0, resm}, 32'd1);
        check("fill0_addr", {25'd0, addr_sm}, 32'd0);
        tick(1);
        check("wr0_first_we", {30'd0, we0, we1}, 32'd2);
        check("wr0_first_addr", {25'd0, buf_addr}, 32'd0);
        check("wr0_first_data", {8'd0, wdata}, 32'h0A0000);
        tick(3);
        check("flush0_resm", {31'd0, resm}, 32'd0);
        check("flush0_full", {31'd0, buf0_full}, 32'd0);
        check("flush0_we", {30'd0, we0, we1}, 32'd2);
        check("flush0_addr", {25'd0, buf_addr}, 32'd3);
        check("flush0_data", {8'd0, wdata}, 32'h0A0003);
        tick(1);
        check("full0_set", {31'd0, buf0_full}, 32'd1);
        check("fill1_resm", {31'd0, resm}, 32'd1);
        check("fill1_addr", {25'd0, addr_sm}, 32'd4);
        tick(2);
        check("wrap_pulse", {31'd0, frame_wrap}, 32'd1);
        check("wrap_addr", {25'd0, addr_sm}, 32'd0);
        tick(1);
        check("wrap_clear", {31'd0, frame_wrap}, 32'd0);
        check("post_wrap_addr", {25'd0, addr_sm}, 32'd1);
        tick(1);
        check("flush1_resm", {31'd0, resm}, 32'd0);
        check("flush1_we", {30'd0, we0, we1}, 32'd1);
        check("flush1_data", {8'd0, wdata}, 32'h0A0001);
        tick(1);
        check("both_full", {30'd0, buf0_full, buf1_full}, 32'd3);
        check("wait_resm", {31'd0, resm}, 32'd0);
        check("wait_addr", {25'd0, addr_sm}, 32'd2);

        // Both buffers held full for 10 cycles
        tick(10);
        check("wait_hold_resm", {31'd0, resm}, 32'd0);
        check("stall_count", {16'd0, stall_count}, STALL_EXP);
        check("wr0_cnt_a", wr0_cnt, 32'd4);
        check("wr1_cnt_a", wr1_cnt, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("buf0_fill_a", {8'd0, buf0_mem[i]}, 32'h0A0000 + i);
            check("buf1_fill_a", {8'd0, buf1_mem[i]}, 32'h0A0000 + ((4 + i) % 6));
        end

        // Release Buffer0 from WAIT
        rel0 = 1'b1;
        tick(1);
        rel0 = 1'b0;
        check("rel0_clear", {31'd0, buf0_full}, 32'd0);
        check("rel0_resm_n1", {31'd0, resm}, 32'd0);
        tick(1);
        check("rel0_resm_n2", {31'd0, resm}, 32'd1);
        check("rel0_addr", {25'd0, addr_sm}, 32'd2);
        tick(4);
        check("flush0b_resm", {31'd0, resm}, 32'd0);
        check("flush0b_we", {30'd0, we0, we1}, 32'd2);
        check("flush0b_data", {8'd0, wdata}, 32'h0A0005);
        check("flush0b_wrap", {31'd0, frame_wrap}, 32'd1);

        // Release Buffer1 in the same cycle Buffer0's FLUSH sets its flag
        rel1 = 1'b1;
        tick(1);
        rel1 = 1'b0;
        check("same_cycle_flags", {30'd0, buf0_full, buf1_full}, 32'd2);
        check("direct_fill1_resm", {31'd0, resm}, 32'd1);
        check("direct_fill1_addr", {25'd0, addr_sm}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("buf0_fill_b", {8'd0, buf0_mem[i]}, 32'h0A0002 + i);
        end

        // Free Buffer0 during the Buffer1 fill, then drop Enable mid-fill
        tick(1);
        rel0 = 1'b1;
        tick(1);
        rel0 = 1'b0;
        check("rel0b_clear", {31'd0, buf0_full}, 32'd0);
        tick(2);
        check("flush1b_we", {30'd0, we0, we1}, 32'd1);
        check("flush1b_data", {8'd0, wdata}, 32'h0A0003);
        tick(1);
        check("full1b_set", {31'd0, buf1_full}, 32'd1);
        check("fill0c_resm", {31'd0, resm}, 32'd1);
        check("fill0c_addr", {25'd0, addr_sm}, 32'd4);
        tick(1);
        check("fill0c_read2", {25'd0, addr_sm}, 32'd5);
        enable = 1'b0;
        tick(3);
        check("flush0c_we", {30'd0, we0, we1}, 32'd2);
        check("flush0c_data", {8'd0, wdata}, 32'h0A0001);
        tick(1);
        check("disable_full", {30'd0, buf0_full, buf1_full}, 32'd3);
        check("disable_resm", {31'd0, resm}, 32'd0);
        tick(5);
        check("idle_resm", {31'd0, resm}, 32'd0);
        check("wr0_cnt_c", wr0_cnt, 32'd12);
        check("wr1_cnt_c", wr1_cnt, 32'd8);
        for (int i = 0; i < 4; i++) begin
            check("buf0_fill_c", {8'd0, buf0_mem[i]}, 32'h0A0000 + ((4 + i) % 6));
            check("buf1_fill_b", {8'd0, buf1_mem[i]}, 32'h0A0000 + i);
        end

        // Restart into Buffer1 and reset mid-fill
        rel0 = 1'b1;
        rel1 = 1'b1;
        tick(1);
        rel0   = 1'b0;
        rel1   = 1'b0;
        enable = 1'b1;
        check("rel_both", {30'd0, buf0_full, buf1_full}, 32'd0);
        tick(1);
        check("fill1c_resm", {31'd0, resm}, 32'd1);
        check("fill1c_addr", {25'd0, addr_sm}, 32'd2);
        tick(1);
        check("fill1c_we", {30'd0, we0, we1}, 32'd1);
        check("fill1c_data", {8'd0, wdata}, 32'h0A0002);
        reset_n = 1'b0;
        #1;
        check("midrst_ctrl", {29'd0, resm, we0, we1}, 32'd0);
        check("midrst_full", {30'd0, buf0_full, buf1_full}, 32'd0);
        check("midrst_addrsm", {25'd0, addr_sm}, 32'd0);
        check("midrst_bufaddr", {25'd0, buf_addr}, 32'd0);
        check("midrst_wdata", {8'd0, wdata}, 32'd0);
        check("midrst_wrap", {31'd0, frame_wrap}, 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        check("restart_resm", {31'd0, resm}, 32'd1);
        check("restart_addr", {25'd0, addr_sm}, 32'd0);
        tick(1);
        check("restart_we", {30'd0, we0, we1}, 32'd2);
        check("restart_bufaddr", {25'd0, buf_addr}, 32'd0);
        check("restart_data", {8'd0, wdata}, 32'h0A0000);
        check("we_exclusive", both_err, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
